// File: rtl/scratchpad_backdoor_port_if.sv
// Purpose: bundles the backdoor request/response handshake and the scratchpad
// memory-port signals of scratchpad_backdoor_port.
//   req_*  : request queue input (valid/ready), write flag, byte address, write data
//   rsp_*  : response output (valid/ready), type echo, read data, error flag
//   busy   : queue non-empty or an access in progress
//   mem_*  : scratchpad wrapper side (grant in, request/strobe/mask/address/data out,
//            registered read data in)
// Modports: slave = the backdoor port itself, master = system/scratchpad side.
interface scratchpad_backdoor_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_write;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    busy;
    logic                    mem_gnt;
    logic                    mem_req;
    logic                    mem_write;
    logic [DATA_WIDTH/8-1:0] mem_mask;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_gnt, mem_rdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               mem_req, mem_write, mem_mask, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_gnt, mem_rdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               mem_req, mem_write, mem_mask, mem_addr, mem_wdata
    );
endinterface

// File: rtl/scratchpad_backdoor_port.sv
// Purpose: backdoor port into the scratchpad memory. Queues 64-bit read/write
// requests in a small FIFO and issues them one at a time onto the scratchpad port
// while the functional traffic is idle (mem_gnt), returning one response per request.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (flushes queue, aborts in-flight access)
//   bd   : scratchpad_backdoor_port_if.slave (req_*, rsp_*, busy, mem_*)
// Optional feature: define SCRATCHPAD_BACKDOOR_ADDR_CHECK_EN to reject requests whose
// address is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) or not 8-byte aligned; rejected
// requests never touch the memory port and respond with rsp_err=1.
module scratchpad_backdoor_port #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    RD_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(32'h10000)
) (
    input logic clk,
    input logic rst,
    scratchpad_backdoor_port_if.slave bd
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ENT_W-1:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [PTR_W:0]          r_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_head_vld;
    logic [ENT_W-1:0]        w_head;
    logic                    w_head_write;
    logic [ADDR_WIDTH-1:0]   w_head_addr;
    logic [DATA_WIDTH-1:0]   w_head_wdata;
    logic                    w_bad;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_mem_req;
    logic                    w_rsp_valid;

    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bd.req_valid && !w_full;

    // With an empty queue the incoming request is the head, so an idle port can
    // issue in the cycle right after acceptance (push and pop cancel in r_count).
    assign w_head_vld   = !w_empty || bd.req_valid;
    assign w_head       = w_empty ? {bd.req_write, bd.req_addr, bd.req_wdata} : r_fifo[r_rptr];
    assign w_head_write = w_head[ENT_W-1];
    assign w_head_addr  = w_head[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_wdata = w_head[DATA_WIDTH-1:0];

`ifdef SCRATCHPAD_BACKDOOR_ADDR_CHECK_EN
    logic [ADDR_WIDTH:0] w_addr_x;
    logic [ADDR_WIDTH:0] w_lo_x;
    logic [ADDR_WIDTH:0] w_hi_x;
    logic                r_err;

    // One extra bit so BASE_ADDR+MEM_BYTES cannot wrap.
    assign w_addr_x = {1'b0, w_head_addr};
    assign w_lo_x   = {1'b0, BASE_ADDR};
    assign w_hi_x   = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};
    assign w_bad    = (w_addr_x < w_lo_x) || (w_addr_x >= w_hi_x) || (w_head_addr[2:0] != 3'b000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_pop) begin
            r_err <= w_bad;
        end
    end

    assign bd.rsp_err = w_rsp_valid && r_err;
`else
    logic w_unused_cfg;

    assign w_bad        = 1'b0;
    assign w_unused_cfg = ^{w_head_addr[2:0], BASE_ADDR, MEM_BYTES};
    assign bd.rsp_err   = 1'b0;
`endif

    // Request queue pointers; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= {bd.req_write, bd.req_addr, bd.req_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Grant is looked at only in IDLE; once issued an access always completes.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_head_vld && w_bad) begin
                    w_pop  = 1'b1;
                    w_next = S_RESP;
                end else if (w_head_vld && bd.mem_gnt) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = r_write ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (bd.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Access context captured at pop; read data cleared so write responses return 0.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_write <= w_head_write;
            r_addr  <= {w_head_addr[ADDR_WIDTH-1:3], 3'b000};
            r_wdata <= w_head_wdata;
            r_rdata <= '0;
        end else if (r_state == S_WAIT && r_cnt == '0) begin
            r_rdata <= bd.mem_rdata;
        end
        if (r_state == S_ISSUE) begin
            r_cnt <= CNT_W'(RD_LATENCY - 1);
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_mem_req   = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_rsp_valid = (r_state == S_RESP);

    assign bd.req_ready = !w_full;
    assign bd.mem_req   = w_mem_req;
    assign bd.mem_write = (r_state == S_ISSUE) && r_write;
    assign bd.mem_mask  = {(DATA_WIDTH/8){w_mem_req}};
    assign bd.mem_addr  = w_mem_req ? r_addr : '0;
    assign bd.mem_wdata = w_mem_req ? r_wdata : '0;
    assign bd.rsp_valid = w_rsp_valid;
    assign bd.rsp_write = w_rsp_valid && r_write;
    assign bd.rsp_rdata = w_rsp_valid ? r_rdata : '0;
    assign bd.busy      = !w_empty || (r_state != S_IDLE);
endmodule
